// File: rtl/imem_loader.sv
// Byte-stream program loader: assembles little-endian words and drives the instruction store write port.
// Optional trailing XOR checksum byte when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_loader #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 31,
    parameter int BASE_ADDR  = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start_i,
    input  logic                         byte_valid_i,
    input  logic [7:0]                   byte_data_i,
    output logic                         byte_ready_o,
    output logic                         wr_en_o,
    output logic [ADDR_WIDTH-1:0]        wr_addr_o,
    output logic [DATA_WIDTH-1:0]        wr_data_o,
    output logic                         cpu_rst_o,
    output logic                         done_o,
    output logic                         error_o,
    output logic [$clog2(DEPTH+1)-1:0]   loaded_count_o
);
    localparam int CW = $clog2(DEPTH+1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_WRITE,
        S_DONE,
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CSUM,
`endif
        S_ERR
    } state_t;

    state_t                  state_reg, state_next;
    logic [1:0]              byte_cnt_reg;
    logic [31:0]             shift_reg;
    logic [31:0]             len_reg;
    logic [CW-1:0]           count_reg;
    logic [ADDR_WIDTH-1:0]   addr_reg;
    logic [DATA_WIDTH-1:0]   data_reg;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]              csum_reg;
`endif

    logic        byte_fire;
    logic        last_byte;
    logic        start_ok;
    logic        collecting;
    logic [31:0] shifted;

    assign byte_fire  = byte_valid_i && byte_ready_o;
    assign last_byte  = byte_fire && (byte_cnt_reg == 2'd3);
    // Shifting in from the top leaves the first byte received in [7:0].
    assign shifted    = {byte_data_i, shift_reg[31:8]};
    assign start_ok   = start_i && (state_reg == S_IDLE || state_reg == S_DONE || state_reg == S_ERR);
    assign collecting = (state_reg == S_LEN) || (state_reg == S_DATA);

    assign wr_addr_o      = addr_reg;
    assign wr_data_o      = data_reg;
    assign loaded_count_o = count_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        byte_ready_o = 1'b0;
        wr_en_o      = 1'b0;
        cpu_rst_o    = 1'b0;
        done_o       = 1'b0;
        error_o      = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (start_i) state_next = S_LEN;
            end
            S_LEN: begin
                byte_ready_o = 1'b1;
                cpu_rst_o    = 1'b1;
                if (last_byte) begin
                    if (shifted == 32'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state_next = S_CSUM;
`else
                        state_next = S_DONE;
`endif
                    end else if (shifted > 32'(DEPTH)) begin
                        state_next = S_ERR;
                    end else begin
                        state_next = S_DATA;
                    end
                end
            end
            S_DATA: begin
                byte_ready_o = 1'b1;
                cpu_rst_o    = 1'b1;
                if (last_byte) state_next = S_WRITE;
            end
            S_WRITE: begin
                wr_en_o   = 1'b1;
                cpu_rst_o = 1'b1;
                if (32'(count_reg) + 32'd1 == len_reg) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    state_next = S_CSUM;
`else
                    state_next = S_DONE;
`endif
                end else begin
                    state_next = S_DATA;
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CSUM: begin
                byte_ready_o = 1'b1;
                cpu_rst_o    = 1'b1;
                if (byte_fire) state_next = (byte_data_i == csum_reg) ? S_DONE : S_ERR;
            end
`endif
            S_DONE: begin
                done_o = 1'b1;
                if (start_i) state_next = S_LEN;
            end
            S_ERR: begin
                error_o   = 1'b1;
                cpu_rst_o = 1'b1;
                if (start_i) state_next = S_LEN;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_cnt_reg <= 2'd0;
            shift_reg    <= 32'd0;
            len_reg      <= 32'd0;
            count_reg    <= '0;
            addr_reg     <= '0;
            data_reg     <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_reg     <= 8'd0;
`endif
        end else begin
            if (start_ok) begin
                byte_cnt_reg <= 2'd0;
                count_reg    <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                csum_reg     <= 8'd0;
`endif
            end
            if (byte_fire && collecting) begin
                byte_cnt_reg <= byte_cnt_reg + 2'd1;
                shift_reg    <= shifted;
`ifdef IMEM_LOADER_CHECKSUM_EN
                csum_reg     <= csum_reg ^ byte_data_i;
`endif
            end
            if (state_reg == S_LEN && last_byte) len_reg <= shifted;
            // Address and data are latched here so they are stable in WRITE and hold afterwards.
            if (state_reg == S_DATA && last_byte) begin
                data_reg <= DATA_WIDTH'(shifted);
                addr_reg <= ADDR_WIDTH'(BASE_ADDR) + (ADDR_WIDTH'(count_reg) << 2);
            end
            if (state_reg == S_WRITE) count_reg <= count_reg + 1'b1;
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed loads with random words and gaps against a list model.
module tb_imem_loader;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int DEPTH = 31;
    localparam int CW    = $clog2(DEPTH+1);

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          byte_valid;
    logic [7:0]    byte_data;
    logic          byte_ready;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          cpu_rst;
    logic          done;
    logic          error;
    logic [CW-1:0] loaded_count;

    imem_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .BASE_ADDR(0)) dut (
        .clk(clk), .rst(rst), .start_i(start), .byte_valid_i(byte_valid), .byte_data_i(byte_data),
        .byte_ready_o(byte_ready), .wr_en_o(wr_en), .wr_addr_o(wr_addr), .wr_data_o(wr_data),
        .cpu_rst_o(cpu_rst), .done_o(done), .error_o(error), .loaded_count_o(loaded_count)
    );

    always #5 clk = ~clk;

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] words [64];
    logic [31:0] got_addr [$];
    logic [31:0] got_data [$];
    logic        got_rst  [$];
    int          cyc = 0;
    int          last_wr_cyc = -1;
    int          done_cyc = -1;
    logic        done_d = 1'b0;

    // Write monitor, sampled mid-cycle.
    always @(negedge clk) begin
        cyc <= cyc + 1;
        done_d <= done;
        if (wr_en === 1'b1) begin
            got_addr.push_back(wr_addr);
            got_data.push_back(wr_data);
            got_rst.push_back(cpu_rst);
            last_wr_cyc <= cyc;
        end
        if (done === 1'b1 && done_d !== 1'b1) done_cyc <= cyc;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int k;
        repeat (gap) step();
        byte_valid = 1'b1;
        byte_data  = b;
        k = 0;
        forever begin
            @(negedge clk);
            if (byte_ready === 1'b1) break;
            k++;
            if (k >= 40) break;
        end
        if (k >= 40) begin
            check("ready_timeout", 64'd0, 64'd1);
            byte_valid = 1'b0;
            step();
        end else begin
            @(posedge clk);
            #1;
            byte_valid = 1'b0;
        end
    endtask

    // Checksum the image would carry: XOR of the length bytes and every word byte.
    function automatic logic [7:0] model_csum(input int n);
        logic [7:0]  x;
        logic [31:0] v;
        v = 32'(n);
        x = v[7:0] ^ v[15:8] ^ v[23:16] ^ v[31:24];
        for (int i = 0; i < n && i < 64; i++) begin
            v = words[i];
            x = x ^ v[7:0] ^ v[15:8] ^ v[23:16] ^ v[31:24];
        end
        return x;
    endfunction

    task automatic run_load(input string tag, input int n, input int max_gap, input bit mid_start,
                            input logic [7:0] flip);
        logic [31:0] v;
        logic [7:0]  csb;
        int          k;
        int          exp_n;
        bit          exp_err;
        csb = model_csum(n) ^ flip;
        got_addr.delete();
        got_data.delete();
        got_rst.delete();
        pulse_start();
        v = 32'(n);
        for (int b = 0; b < 4; b++) send_byte(v[8*b +: 8], $urandom_range(0, max_gap));
        if (n <= DEPTH) begin
            for (int i = 0; i < n; i++) begin
                v = words[i];
                for (int b = 0; b < 4; b++) begin
                    send_byte(v[8*b +: 8], $urandom_range(0, max_gap));
                    if (mid_start && i == 0 && b == 1) pulse_start();
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            send_byte(csb, $urandom_range(0, max_gap));
`endif
        end
        k = 0;
        while (!(done === 1'b1 || error === 1'b1) && k < 40) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_finished"}, 64'(k < 40), 64'd1);
        repeat (3) step();

        exp_n   = (n <= DEPTH) ? n : 0;
        exp_err = (n > DEPTH);
`ifdef IMEM_LOADER_CHECKSUM_EN
        exp_err = exp_err || (flip != 8'h00);
`endif
        check({tag, "_nwrites"}, 64'(got_addr.size()), 64'(exp_n));
        for (int i = 0; i < got_addr.size() && i < exp_n; i++) begin
            check($sformatf("%s_addr%0d", tag, i), 64'(got_addr[i]), 64'(4 * i));
            check($sformatf("%s_data%0d", tag, i), 64'(got_data[i]), 64'(words[i]));
            check($sformatf("%s_cpurst_wr%0d", tag, i), 64'(got_rst[i]), 64'd1);
        end
`ifndef IMEM_LOADER_CHECKSUM_EN
        if (exp_n > 0) check({tag, "_done_lat"}, 64'(done_cyc - last_wr_cyc), 64'd1);
`endif
        check({tag, "_count"}, 64'(loaded_count), 64'(exp_n));
        check({tag, "_done"}, 64'(done), 64'(!exp_err));
        check({tag, "_error"}, 64'(error), 64'(exp_err));
        check({tag, "_cpu_rst"}, 64'(cpu_rst), 64'(exp_err));
        check({tag, "_ready"}, 64'(byte_ready), 64'd0);
        check({tag, "_wr_en"}, 64'(wr_en), 64'd0);
        $display("load %s: n=%0d writes=%0d done=%0b error=%0b csum=%02h", tag, n,
                 got_addr.size(), done, error, csb);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"}, 64'(byte_ready), 64'd0);
        check({tag, "_wr_en"}, 64'(wr_en), 64'd0);
        check({tag, "_addr"}, 64'(wr_addr), 64'd0);
        check({tag, "_data"}, 64'(wr_data), 64'd0);
        check({tag, "_cpu_rst"}, 64'(cpu_rst), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_error"}, 64'(error), 64'd0);
        check({tag, "_count"}, 64'(loaded_count), 64'd0);
    endtask

    initial begin
        logic [31:0] v;
        rst = 1'b1;
        start = 1'b0;
        byte_valid = 1'b0;
        byte_data = 8'h00;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        step();

        words[0] = 32'h00500093;
        words[1] = 32'h00A00113;
        run_load("n2", 2, 0, 1'b0, 8'h00);
        run_load("n0", 0, 0, 1'b0, 8'h00);
        run_load("n32", 32, 0, 1'b0, 8'h00);
        words[0] = $urandom;
        run_load("n1_after_err", 1, 0, 1'b0, 8'h00);

        for (int i = 0; i < 64; i++) words[i] = $urandom;
        run_load("n5_nogap", 5, 0, 1'b0, 8'h00);
        run_load("n5_gaps_midstart", 5, 5, 1'b1, 8'h00);
        run_load("n31_max", DEPTH, 1, 1'b0, 8'h00);

        // Reset between edges while assembling the second word of a 3-word image.
        got_addr.delete();
        got_data.delete();
        got_rst.delete();
        pulse_start();
        v = 32'd3;
        for (int b = 0; b < 4; b++) send_byte(v[8*b +: 8], 0);
        v = words[0];
        for (int b = 0; b < 4; b++) send_byte(v[8*b +: 8], 0);
        v = words[1];
        for (int b = 0; b < 2; b++) send_byte(v[8*b +: 8], 0);
        check("midrst_prewrites", 64'(got_addr.size()), 64'd1);
        #3;
        rst = 1'b1;
        #1;
        check_all_zero("midrst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        step();
        run_load("restart_n3", 3, 2, 1'b0, 8'h00);

`ifdef IMEM_LOADER_CHECKSUM_EN
        words[0] = $urandom;
        run_load("csum_ok", 1, 0, 1'b0, 8'h00);
        run_load("csum_bad", 1, 0, 1'b0, 8'h01);
        run_load("csum_n0", 0, 0, 1'b0, 8'h00);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction memory: receives a program as a byte stream and emits word writes into the instruction store.
- The store's read port is unchanged; this block drives its write port.
- Holds the core in reset while loading and releases it when the image is complete.
- Sits between a byte source (UART/debug bridge or testbench) and the instruction store.

Parameters:
ADDR_WIDTH, 32, width of wr_addr_o (byte address)
DATA_WIDTH, 32, instruction word width; fixed at 32 (4 bytes per word)
DEPTH, 31, number of words in the instruction store
BASE_ADDR, 0, byte address of word 0; must be word aligned

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
start_i  input  1  one-cycle pulse that begins a load
byte_valid_i  input  1  byte_data_i is valid
byte_data_i  input  8  program stream byte
byte_ready_o  output  1  loader accepts a byte this cycle
wr_en_o  output  1  one-cycle write strobe to the instruction store
wr_addr_o  output  ADDR_WIDTH  byte address of the word being written
wr_data_o  output  DATA_WIDTH  instruction word being written
cpu_rst_o  output  1  holds the core in reset during a load
done_o  output  1  image loaded (level)
error_o  output  1  image rejected (level)
loaded_count_o  output  $clog2(DEPTH+1)  number of words written in the current load

Behaviour:
- Reset (async, immediate, including mid-load):
  - State goes to IDLE.
  - All outputs are 0; word index and byte counter are cleared.
  - Any in-flight word is discarded; wr_en_o drops at once.
- Byte handshake:
  - A byte transfers on a rising edge with byte_valid_i && byte_ready_o.
  - byte_ready_o is 1 only in LEN, DATA and CSUM; it does not depend on byte_valid_i.
  - byte_valid_i gaps of any length are legal.
- Stream format: 4-byte word count N, little-endian, then N words, each little-endian (first byte goes to [7:0]).
- States:
  - IDLE: start_i -> LEN, cpu_rst_o=1.
  - LEN: collect 4 bytes. On the 4th byte:
    - N==0 -> DONE.
    - N>DEPTH -> ERR.
    - otherwise -> DATA.
  - DATA: collect 4 bytes into the assembly register; on the 4th byte -> WRITE.
  - WRITE: exactly one cycle.
    - wr_en_o=1, wr_addr_o=BASE_ADDR+4*idx, wr_data_o=assembled word; byte_ready_o=0.
    - idx and loaded_count_o increment at the end of the cycle.
    - If idx+1==N -> DONE (or CSUM when the optional feature is enabled); else -> DATA.
  - DONE: done_o=1, cpu_rst_o=0, held until start_i.
  - ERR: error_o=1, cpu_rst_o stays 1, held until start_i.
- Latency: the write strobe occurs in the cycle after the 4th byte of a word is accepted; minimum 5 cycles per word.
- start_i:
  - In IDLE, DONE or ERR: -> LEN. Clears done_o, error_o, idx, loaded_count_o and the byte counter; sets cpu_rst_o=1.
  - In LEN/DATA/WRITE/CSUM: ignored.
- Outside WRITE, wr_en_o=0 and wr_addr_o/wr_data_o hold their last values.
- Address arithmetic: 4*idx is computed at ADDR_WIDTH and wraps modulo 2^ADDR_WIDTH; no overflow occurs for legal DEPTH.

Optional Feature:
IMEM_LOADER_CHECKSUM_EN
- Defined:
  - After the last WRITE the FSM enters CSUM and accepts one byte.
  - Valid checksum = XOR of every image byte, including the 4 length bytes.
  - Match -> DONE; mismatch -> ERR.
  - N==0: CSUM follows LEN, and the XOR covers the length bytes only.
  - Words already written are not retracted on mismatch.
- Not defined: no CSUM state; the stream ends after the last data byte.

Test Plan:
- Normal load, N=2, words 0x00500093, 0x00A00113, bytes sent back-to-back:
  - wr_en_o pulses at addr 0x0 then 0x4 with those data values.
  - loaded_count_o ends at 2; done_o=1; cpu_rst_o falls the cycle after the 2nd write.
- N=0: no wr_en_o pulse; done_o=1 after the 4th length byte; loaded_count_o=0.
- N=32 with DEPTH=31: error_o=1, no writes, byte_ready_o=0, cpu_rst_o stays 1. A following start_i then a valid N=1 image loads correctly.
- Random 0-5 cycle byte_valid_i gaps plus a start_i pulse mid-DATA: written words and addresses are identical to the gap-free run; the mid-load start_i has no effect.
- rst asserted mid-DATA after 1 word written, between clock edges:
  - All outputs go to 0 immediately.
  - Restarting with N=3 writes addrs 0x0/0x4/0x8; loaded_count_o=3.
- With IMEM_LOADER_CHECKSUM_EN, N=1 image:
  - Correct XOR byte -> done_o=1.
  - Same image with checksum^0x01 -> error_o=1, the word at addr 0x0 still written once.
